branch_resolve_unit: RTL and testbench

Multi-cycle branch comparator and resolver. It sits at the consumer end of the BrUn control signal. It takes the branch operands, funct3 and the BrUn decision from decode, and compares the operands CHUNK bits per cycle starting at the MSB, stopping early once a chunk differs. It returns BrEq, BrLt and a taken flag to the PC-select logic over a valid/ready handshake, and any in-flight branch can be flushed.

---
 rtl/branch_resolve_unit.sv | 117 +++++++++++
 tb/tb_branch_resolve_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Multi-cycle branch comparator: compares operands CHUNK bits per cycle from the MSB,
// stops at the first differing chunk and returns eq/lt/taken over a valid/ready handshake.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            br_un,
    input  logic [2:0]      funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            br_eq,
    output logic            br_lt,
    output logic            br_taken,
    output logic            busy
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [2:0]      f3_q;
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] sign_flip;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic            last;

    // Flipping the sign bit maps signed order onto unsigned order.
    assign sign_flip = {~br_un, {(XLEN-1){1'b0}}};

    // Operands shift left each cycle, so the chunk under test is always the top one.
    assign a_ch = a_q[XLEN-1 -: CHUNK];
    assign b_ch = b_q[XLEN-1 -: CHUNK];
    assign last = (idx == IW'(NCHUNK - 1));

    assign in_ready = rst_n && (state == IDLE);
    assign busy     = (state != IDLE);

    function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:  return eq;
            3'b001:  return !eq;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return lt;
            3'b111:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            f3_q      <= '0;
            out_valid <= 1'b0;
            br_eq     <= 1'b0;
            br_lt     <= 1'b0;
            br_taken  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= rs1 ^ sign_flip;
                        b_q   <= rs2 ^ sign_flip;
                        f3_q  <= funct3;
                        idx   <= '0;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (a_ch != b_ch) begin
                        br_eq     <= 1'b0;
                        br_lt     <= (a_ch < b_ch);
                        br_taken  <= taken_of(f3_q, 1'b0, (a_ch < b_ch));
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (last) begin
                        br_eq     <= 1'b1;
                        br_lt     <= 1'b0;
                        br_taken  <= taken_of(f3_q, 1'b1, 1'b0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                        a_q <= a_q << CHUNK;
                        b_q <= b_q << CHUNK;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: transaction-level reference model,
// per-cycle compare process, directed cases with literal expectations, random traffic.
module tb_branch_resolve_unit;

    localparam int XLEN   = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = XLEN / CHUNK;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            br_un;
    logic [2:0]      funct3;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            br_eq;
    logic            br_lt;
    logic            br_taken;
    logic            busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .br_un(br_un), .funct3(funct3), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .br_eq(br_eq), .br_lt(br_lt),
        .br_taken(br_taken), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: outcome from plain comparisons, latency from the first differing chunk.
    function automatic void ref_resolve(input logic [31:0] a, input logic [31:0] b, input logic bu,
                                        input logic [2:0] f3, output logic eq, output logic lt,
                                        output logic tk, output int lat);
        logic [31:0] x;
        int h;
        eq = (a == b);
        lt = bu ? (a < b) : ($signed(a) < $signed(b));
        case (f3)
            3'd0: tk = eq;
            3'd1: tk = !eq;
            3'd4, 3'd6: tk = lt;
            3'd5, 3'd7: tk = !lt;
            default: tk = 1'b0;
        endcase
        x = a ^ b;
        h = -1;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (x[i] && h < 0) h = i;
        end
        lat = (h < 0) ? NCHUNK : ((XLEN - 1 - h) / CHUNK + 1);
    endfunction

    logic m_busy, m_valid, m_eq, m_lt, m_taken, p_eq, p_lt, p_taken;
    logic r_eq, r_lt, r_tk;
    int   r_lat;
    int   m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
            m_eq <= 1'b0; m_lt <= 1'b0; m_taken <= 1'b0;
        end else if (flush) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                ref_resolve(rs1, rs2, br_un, funct3, r_eq, r_lt, r_tk, r_lat);
                m_busy <= 1'b1; m_cnt <= r_lat;
                p_eq <= r_eq; p_lt <= r_lt; p_taken <= r_tk;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid <= 1'b1; m_eq <= p_eq; m_lt <= p_lt; m_taken <= p_taken;
            end
        end else if (out_ready) begin
            m_busy <= 1'b0; m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_valid);
            check("busy", busy, m_busy);
            check("in_ready", in_ready, rst_n && !m_busy);
            if (m_valid) begin
                check("br_eq", br_eq, m_eq);
                check("br_lt", br_lt, m_lt);
                check("br_taken", br_taken, m_taken);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_wait", in_ready, 1);
    endtask

    task automatic setup(input logic [31:0] a, input logic [31:0] b, input logic bu, input logic [2:0] f3);
        rs1 = a; rs2 = b; br_un = bu; funct3 = f3; in_valid = 1'b1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic req(input string name, input logic [31:0] a, input logic [31:0] b, input logic bu,
                       input logic [2:0] f3, input logic e_eq, input logic e_lt, input logic e_tk,
                       input int e_lat);
        int lat;
        @(negedge clk);
        wait_idle();
        setup(a, b, bu, f3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check({name, "_lat"}, lat, e_lat);
        check({name, "_eq"}, br_eq, e_eq);
        check({name, "_lt"}, br_lt, e_lt);
        check({name, "_taken"}, br_taken, e_tk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; br_un = 1'b0; funct3 = '0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_br_eq", br_eq, 0);
        check("rst_br_lt", br_lt, 0);
        check("rst_br_taken", br_taken, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        req("beq_equal", 32'h12345678, 32'h12345678, 1'b0, 3'b000, 1, 0, 1, 4);
        req("blt_signed", 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 0, 1, 1, 1);
        req("bltu", 32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b110, 0, 0, 0, 1);
        req("bgeu", 32'h00000100, 32'h00000200, 1'b1, 3'b111, 0, 1, 0, 3);
        req("bge_signed", 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b101, 0, 1, 0, 1);
        req("f3_010", 32'd5, 32'd5, 1'b0, 3'b010, 1, 0, 0, 4);
        req("bne_last", 32'hABCDEF00, 32'hABCDEF01, 1'b1, 3'b001, 0, 1, 1, 4);

        // Back-pressure: result held, new requests ignored.
        @(negedge clk);
        wait_idle();
        setup(32'h00000100, 32'h00000200, 1'b1, 3'b111);
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            setup($urandom, $urandom, 1'b0, 3'b000);
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_eq", br_eq, 0);
            check("bp_lt", br_lt, 1);
            check("bp_taken", br_taken, 0);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        req("after_bp", 32'h00000007, 32'h00000003, 1'b1, 3'b101, 0, 0, 1, 4);

        // Flush in the second COMPARE cycle.
        @(negedge clk);
        wait_idle();
        setup(32'h12345678, 32'h12345678, 1'b0, 3'b000);
        @(posedge clk);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        check("flush_busy", busy, 0);
        @(negedge clk) flush = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_valid", seen, 0);

        // Flush beats in_valid in IDLE.
        @(negedge clk);
        setup(32'h1, 32'h2, 1'b1, 3'b110);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush_idle_busy", busy, 0);
        check("flush_idle_ready", in_ready, 1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // Async reset mid-COMPARE, after a prior result left eq/taken high.
        req("pre_reset", 32'h0, 32'h0, 1'b1, 3'b000, 1, 0, 1, 4);
        @(negedge clk);
        wait_idle();
        setup(32'h12345678, 32'h12345678, 1'b0, 3'b000);
        @(posedge clk);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_br_eq", br_eq, 0);
        check("arst_br_lt", br_lt, 0);
        check("arst_br_taken", br_taken, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = $urandom_range(0, 1);
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            br_un     = $urandom_range(0, 1);
            funct3    = 3'($urandom_range(0, 7));
            rs1       = $urandom;
            case ($urandom_range(0, 2))
                0: rs2 = rs1;
                1: rs2 = rs1 ^ (32'h1 << $urandom_range(0, 31));
                default: rs2 = $urandom;
            endcase
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
